// File: rtl/md_sequencer_if.sv
// Multiply/divide sequencer port bundle between the E-stage controller and the HI/LO unit.
// Latency: none; wires only.
// Backpressure: none here; the controller sees mdrunE/stallmdD and holds off new work itself.
interface md_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             mdstartE;
  logic [1:0]       mdopE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic [1:0]       hilodisableE;
  logic [WIDTH-1:0] hilowdE;
  logic             hiloaccessD;
  logic             mdrunE;
  logic             stallmdD;
  logic [WIDTH-1:0] hiE;
  logic [WIDTH-1:0] loE;

  // Controller / pipeline side
  modport master (
    output mdstartE, mdopE, srcaE, srcbE, hilodisableE, hilowdE, hiloaccessD,
    input  mdrunE, stallmdD, hiE, loE
  );

  // Multiply/divide unit side
  modport slave (
    input  mdstartE, mdopE, srcaE, srcbE, hilodisableE, hilowdE, hiloaccessD,
    output mdrunE, stallmdD, hiE, loE
  );
endinterface

// File: rtl/md_sequencer.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO, with its IDLE->RUN->FIX sequencer.
// Latency: WIDTH RUN cycles + 1 FIX cycle (mult may finish early with MD_EARLY_OUT_EN defined).
// Backpressure: mdrunE busy flag; stallmdD holds D-stage HI/LO accesses until the result lands.
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave md
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  state_t             state_nxt;

  // sequencer strobes
  logic               load;
  logic               step;
  logic               commit;
  logic               mt_hi;
  logic               mt_lo;

  // operation context captured at start
  logic               is_div;
  logic               res_neg;    // product / quotient must be negated
  logic               rem_neg;    // remainder takes the dividend's sign
  logic               bzero;      // divide by zero
  logic [WIDTH-1:0]   orig_a;
  logic [CW-1:0]      cnt;

  // datapath
  // Mult: acc accumulates the product; mcand is the multiplicand shifted left by
  //       the step count and opb is the multiplier shifted right, so acc always
  //       holds an exactly aligned partial product (this is what makes early-out
  //       bit-identical).
  // Div:  acc = {remainder, dividend/quotient}; opb holds the divisor.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  // start-time operand conditioning
  logic               start_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  // step / result helpers
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_sum;
  logic               last_step;
  logic               early_done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  assign md.mdrunE   = (state != IDLE);
  assign md.stallmdD = md.hiloaccessD & md.mdrunE;
  assign md.hiE      = hi;
  assign md.loE      = lo;

  // Operand magnitudes and sign flags for the op being started this cycle
  always_comb begin
    start_signed = ~md.mdopE[0];
    a_neg        = start_signed & md.srcaE[WIDTH-1];
    b_neg        = start_signed & md.srcbE[WIDTH-1];
    a_abs        = a_neg ? (~md.srcaE + 1'b1) : md.srcaE;
    b_abs        = b_neg ? (~md.srcbE + 1'b1) : md.srcbE;
  end

  // One radix-2 step: trial subtract for divide, conditional add for multiply
  always_comb begin
    div_diff  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    mul_sum   = acc + (opb[0] ? mcand : '0);
    last_step = (cnt == CW'(WIDTH-1));
`ifdef MD_EARLY_OUT_EN
    // Multiplier bits not yet consumed are all zero: product is already final.
    early_done = ~is_div & (opb[WIDTH-1:1] == '0);
`else
    early_done = 1'b0;
`endif
  end

  // Sign correction and special cases applied in FIX
  always_comb begin
    prod   = res_neg ? (~acc + 1'b1) : acc;
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (is_div) begin
      if (bzero) begin
        lo_res = '1;
        hi_res = orig_a;
      end else begin
        // Most-negative / -1 falls out naturally: |q| = 2^(W-1), negated to itself.
        lo_res = res_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        hi_res = rem_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and datapath strobes; a start beats a same-cycle MTHI/MTLO
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (md.mdstartE) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          mt_hi = ~md.hilodisableE[1];
          mt_lo = ~md.hilodisableE[0];
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_step || early_done) state_nxt = FIX;
      end
      FIX: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and HI/LO; HI/LO only change on FIX commit or an idle MTHI/MTLO
  always_ff @(posedge clk) begin
    if (reset) begin
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      bzero   <= 1'b0;
      orig_a  <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      opb     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (load) begin
        is_div  <= md.mdopE[1];
        res_neg <= a_neg ^ b_neg;
        rem_neg <= a_neg;
        bzero   <= (md.srcbE == '0);
        orig_a  <= md.srcaE;
        cnt     <= '0;
        acc     <= md.mdopE[1] ? {{WIDTH{1'b0}}, a_abs} : '0;
        mcand   <= {{WIDTH{1'b0}}, a_abs};
        opb     <= b_abs;
      end
      if (step) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          if (div_diff[WIDTH]) acc <= {acc[2*WIDTH-2:0], 1'b0};
          else                 acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
          acc   <= mul_sum;
          mcand <= {mcand[2*WIDTH-2:0], 1'b0};
          opb   <= {1'b0, opb[WIDTH-1:1]};
        end
      end
      if (commit) begin
        hi <= hi_res;
        lo <= lo_res;
      end
      if (mt_hi) hi <= md.hilowdE;
      if (mt_lo) lo <= md.hilowdE;
    end
  end

  // The hazard unit never starts a new op while one is running
  a_no_restart: assert property (@(posedge clk) disable iff (reset)
                                 !(md.mdstartE && md.mdrunE));

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: scoreboarded mult/div results, run length, stall, MTHI/MTLO, reset.
// Latency: expects WIDTH+1 busy cycles (fewer for mult when MD_EARLY_OUT_EN is defined).
// Backpressure: drives hiloaccessD during runs and checks the stall window.
module tb_md_sequencer;

  localparam int W = 32;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  exp_t sb[$];

  md_sequencer_if #(.WIDTH(W)) mdif ();

  md_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference results from plain integer arithmetic
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      p;
    logic [63:0] u;
    logic [31:0] bm;
    int          steps;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {e.hi, e.lo} = p;
      end
      2'b01: begin
        u = {32'b0, a} * {32'b0, b};
        {e.hi, e.lo} = u;
      end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
        end else if (op == 2'b10) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'd0;
          end else begin
            e.lo = $signed(a) / $signed(b);
            e.hi = $signed(a) % $signed(b);
          end
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    e.cyc = W + 1;
`ifdef MD_EARLY_OUT_EN
    if (!op[1]) begin
      bm    = (op == 2'b00 && b[31]) ? (~b + 32'd1) : b;
      steps = 1;
      for (int i = 0; i < W; i++) if (bm[i]) steps = i + 1;
      e.cyc = steps + 1;
    end
`else
    bm    = 32'd0;
    steps = 0;
`endif
    return e;
  endfunction

  // Launch one op, watch it run, then compare against the scoreboard head
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit disturb, input bit clash);
    exp_t        e;
    int          cyc;
    int          stalls;
    int          changed;
    logic [31:0] h0;
    logic [31:0] l0;
    sb.push_back(model(op, a, b));
    h0 = mdif.hiE;
    l0 = mdif.loE;
    mdif.mdstartE = 1'b1;
    mdif.mdopE    = op;
    mdif.srcaE    = a;
    mdif.srcbE    = b;
    if (clash) begin
      mdif.hilodisableE = 2'b00;
      mdif.hilowdE      = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    mdif.mdstartE     = 1'b0;
    mdif.hilodisableE = 2'b11;
    mdif.srcaE        = $urandom;
    mdif.srcbE        = $urandom;
    cyc     = 0;
    stalls  = 0;
    changed = 0;
    while (mdif.mdrunE && cyc < 200) begin
      cyc++;
      if (mdif.stallmdD) stalls++;
      if (mdif.hiE !== h0 || mdif.loE !== l0) changed++;
      if (disturb && cyc == 4) mdif.hiloaccessD = 1'b1;
      if (disturb && cyc == 6) begin
        mdif.hilodisableE = 2'b01;
        mdif.hilowdE      = 32'h0000_1234;
      end
      @(negedge clk);
    end
    mdif.hilodisableE = 2'b11;
    e = sb.pop_front();
    chk("run_cycles", 64'(cyc), 64'(e.cyc));
    chk("hi", {32'b0, mdif.hiE}, {32'b0, e.hi});
    chk("lo", {32'b0, mdif.loE}, {32'b0, e.lo});
    chk("hold_during_run", 64'(changed), 64'd0);
    if (disturb) begin
      chk("stall_cycles", 64'(stalls), 64'(e.cyc - 4));
      chk("stall_drop", {63'b0, mdif.stallmdD}, 64'd0);
      mdif.hiloaccessD = 1'b0;
    end
  endtask

  // MTHI/MTLO write while idle
  task automatic do_mt(input logic [1:0] dis, input logic [31:0] wd,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    mdif.hilodisableE = dis;
    mdif.hilowdE      = wd;
    @(negedge clk);
    mdif.hilodisableE = 2'b11;
    chk("mt_hi", {32'b0, mdif.hiE}, {32'b0, exp_hi});
    chk("mt_lo", {32'b0, mdif.loE}, {32'b0, exp_lo});
  endtask

  initial begin
    int          t;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_chk  = 0;
    n_pass = 0;
    reset             = 1'b1;
    mdif.mdstartE     = 1'b0;
    mdif.mdopE        = 2'b00;
    mdif.srcaE        = 32'd0;
    mdif.srcbE        = 32'd0;
    mdif.hilodisableE = 2'b11;
    mdif.hilowdE      = 32'd0;
    mdif.hiloaccessD  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hi", {32'b0, mdif.hiE}, 64'd0);
    chk("rst_lo", {32'b0, mdif.loE}, 64'd0);
    chk("rst_run", {63'b0, mdif.mdrunE}, 64'd0);
    chk("rst_stall", {63'b0, mdif.stallmdD}, 64'd0);
    reset            = 1'b0;
    mdif.hiloaccessD = 1'b0;
    @(negedge clk);

    // directed cases
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    do_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0, 1'b0);
    do_op(2'b00, 32'h0000_1234, 32'h8000_0000, 1'b0, 1'b0);
    do_op(2'b01, 32'd5, 32'd3, 1'b0, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    // stall window plus an MTHI attempt while running
    do_op(2'b00, 32'h0001_0001, 32'hFFFF_0003, 1'b1, 1'b0);

    // idle MTHI/MTLO
    do_mt(2'b01, 32'hCAFE_0001, 32'hCAFE_0001, mdif.loE);
    do_mt(2'b10, 32'h0BAD_F00D, 32'hCAFE_0001, 32'h0BAD_F00D);
    do_mt(2'b00, 32'h5555_AAAA, 32'h5555_AAAA, 32'h5555_AAAA);
    // start wins over a same-cycle MTHI/MTLO
    do_op(2'b11, 32'd1000, 32'd33, 1'b0, 1'b1);

    // reset mid-run
    mdif.mdstartE = 1'b1;
    mdif.mdopE    = 2'b01;
    mdif.srcaE    = 32'h1234_5678;
    mdif.srcbE    = 32'h8765_4321;
    @(negedge clk);
    mdif.mdstartE = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_run_busy", {63'b0, mdif.mdrunE}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_run", {63'b0, mdif.mdrunE}, 64'd0);
    chk("rst_mid_hi", {32'b0, mdif.hiE}, 64'd0);
    chk("rst_mid_lo", {32'b0, mdif.loE}, 64'd0);
    do_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0);

    // random mix
    for (t = 0; t < 8; t++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (t == 3) ? 32'd0 : ((t == 5) ? 32'($urandom_range(1, 9)) : $urandom);
      do_op(rop, ra, rb, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
